// File: rtl/udp_img_packetizer.sv
// Slices one IMG_WIDTH x IMG_HEIGHT image per frame period into UDP packets: a 32-byte header, then pixel payload.
// Optional macro UDP_PKT_CHKSUM_EN appends a 16-bit payload-sum trailer (low byte first) to every packet.
module udp_img_packetizer #(
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter int unsigned BYTES_PER_PIX = 3,
  parameter int unsigned PAYLOAD_BYTES = 636,
  parameter logic [31:0] HEADER_MAGIC  = 32'hAA0055FF,
  parameter int unsigned FRAME_GAP_CYC = 2000,
  parameter int unsigned PKT_GAP_CYC   = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        read_req,
  input  logic        read_req_ack,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] pic_seq
);

  localparam int unsigned IMG_TOTAL  = IMG_WIDTH * IMG_HEIGHT * BYTES_PER_PIX;
  localparam int unsigned PKT_TOTAL  = (IMG_TOTAL + PAYLOAD_BYTES - 1) / PAYLOAD_BYTES;
  localparam int unsigned LAST_BYTES = IMG_TOTAL - (PKT_TOTAL - 1) * PAYLOAD_BYTES;
`ifdef UDP_PKT_CHKSUM_EN
  localparam int unsigned LEN_OVH = 34;
`else
  localparam int unsigned LEN_OVH = 32;
`endif
  localparam logic [1:0] LANE_BASE = 2'(4 - BYTES_PER_PIX);
  localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_PIX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FRAME_GAP, S_REQ_UDP, S_WAIT_ACK, S_SEND_HDR,
    S_REQ_DATA, S_SEND_DATA, S_SEND_TRL, S_PKT_GAP
  } state_t;

  state_t      r_state;
  logic [31:0] r_gap_cnt;
  logic [31:0] r_pic_seq;
  logic [31:0] r_pkt_seq;
  logic [31:0] r_offset;
  logic [4:0]  r_hdr_idx;
  logic [15:0] r_pay_cnt;
  logic [31:0] r_word;
  logic        r_held;
  logic [1:0]  r_lane;
  logic        r_read_req;
  logic        r_req;
  logic        r_valid;
  logic [7:0]  r_data;
  logic [15:0] r_len;
  logic        r_frame_done;
`ifdef UDP_PKT_CHKSUM_EN
  logic [15:0] r_sum;
  logic        r_trl_hi;
`endif

  logic        w_last_pkt;
  logic [15:0] w_cur_bytes;
  logic [31:0] w_hdr_word;
  logic [7:0]  w_hdr_byte;
  logic [1:0]  w_lane_sel;
  logic [7:0]  w_pix_byte;
  logic        w_fgap_done;
  logic        w_pgap_done;

  assign w_last_pkt  = (r_pkt_seq == 32'(PKT_TOTAL - 1));
  assign w_cur_bytes = w_last_pkt ? 16'(LAST_BYTES) : 16'(PAYLOAD_BYTES);
  assign w_fgap_done = (r_gap_cnt + 32'd1 >= 32'(FRAME_GAP_CYC));
  assign w_pgap_done = (r_gap_cnt + 32'd1 >= 32'(PKT_GAP_CYC));
  assign w_lane_sel  = LANE_BASE + r_lane;
  assign w_pix_byte  = r_word[{w_lane_sel, 3'b000} +: 8];
  assign w_hdr_byte  = w_hdr_word[{r_hdr_idx[1:0], 3'b000} +: 8];

  always_comb begin
    w_hdr_word = '0;
    case (r_hdr_idx[4:2])
      3'd0:    w_hdr_word = HEADER_MAGIC;
      3'd1:    w_hdr_word = 32'(IMG_WIDTH);
      3'd2:    w_hdr_word = 32'(IMG_HEIGHT);
      3'd3:    w_hdr_word = 32'(IMG_TOTAL);
      3'd4:    w_hdr_word = r_offset;
      3'd5:    w_hdr_word = r_pic_seq;
      3'd6:    w_hdr_word = r_pkt_seq;
      default: w_hdr_word = {16'd0, w_cur_bytes};
    endcase
  end

  assign read_req            = r_read_req;
  assign pix_ready           = (r_state == S_SEND_DATA) && !r_held;
  assign app_tx_data_request = r_req;
  assign app_tx_data_valid   = r_valid;
  assign app_tx_data         = r_data;
  assign udp_data_length     = r_len;
  assign busy                = (r_state != S_IDLE);
  assign frame_done          = r_frame_done;
  assign pic_seq             = r_pic_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_pic_seq    <= '0;
      r_pkt_seq    <= '0;
      r_offset     <= '0;
      r_hdr_idx    <= '0;
      r_pay_cnt    <= '0;
      r_word       <= '0;
      r_held       <= 1'b0;
      r_lane       <= '0;
      r_read_req   <= 1'b0;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_len        <= 16'(32 + PAYLOAD_BYTES);
      r_frame_done <= 1'b0;
`ifdef UDP_PKT_CHKSUM_EN
      r_sum        <= '0;
      r_trl_hi     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_pic_seq <= r_pic_seq + 32'd1;
            r_pkt_seq <= '0;
            r_offset  <= '0;
            r_lane    <= '0;
            r_held    <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= S_FRAME_GAP;
          end
        end
        S_FRAME_GAP: begin
          if (w_fgap_done) begin
            r_gap_cnt <= '0;
            r_req     <= 1'b1;
            r_state   <= S_REQ_UDP;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        S_REQ_UDP: begin
          if (udp_tx_ready) r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (app_tx_ack) begin
            r_req     <= 1'b0;
            r_len     <= 16'(LEN_OVH) + w_cur_bytes;
            r_valid   <= 1'b1;
            r_data    <= HEADER_MAGIC[7:0];
            r_hdr_idx <= 5'd1;
            r_pay_cnt <= '0;
`ifdef UDP_PKT_CHKSUM_EN
            r_sum     <= '0;
            r_trl_hi  <= 1'b0;
`endif
            r_state   <= S_SEND_HDR;
          end
        end
        S_SEND_HDR: begin
          r_data    <= w_hdr_byte;
          r_hdr_idx <= r_hdr_idx + 5'd1;
          if (r_hdr_idx == 5'd31) begin
            r_read_req <= 1'b1;
            r_state    <= S_REQ_DATA;
          end
        end
        S_REQ_DATA: begin
          r_valid <= 1'b0;
          if (read_req_ack) begin
            r_read_req <= 1'b0;
            r_state    <= S_SEND_DATA;
          end
        end
        S_SEND_DATA: begin
          // A held word (possibly left over from the previous packet) drains before any new word is taken.
          if (r_held) begin
            r_valid   <= 1'b1;
            r_data    <= w_pix_byte;
            r_pay_cnt <= r_pay_cnt + 16'd1;
`ifdef UDP_PKT_CHKSUM_EN
            r_sum     <= r_sum + {8'd0, w_pix_byte};
`endif
            if (r_lane == LANE_LAST) begin
              r_lane <= '0;
              r_held <= 1'b0;
            end else begin
              r_lane <= r_lane + 2'd1;
            end
            if (r_pay_cnt == w_cur_bytes - 16'd1) begin
              r_gap_cnt <= '0;
`ifdef UDP_PKT_CHKSUM_EN
              r_state   <= S_SEND_TRL;
`else
              r_state   <= S_PKT_GAP;
`endif
            end
          end else begin
            r_valid <= 1'b0;
            if (pix_valid) begin
              r_word <= pix_data;
              r_held <= 1'b1;
            end
          end
        end
`ifdef UDP_PKT_CHKSUM_EN
        S_SEND_TRL: begin
          r_valid  <= 1'b1;
          r_data   <= r_trl_hi ? r_sum[15:8] : r_sum[7:0];
          r_trl_hi <= ~r_trl_hi;
          if (r_trl_hi) r_state <= S_PKT_GAP;
        end
`endif
        S_PKT_GAP: begin
          r_valid <= 1'b0;
          if (w_pgap_done) begin
            r_gap_cnt <= '0;
            r_pkt_seq <= r_pkt_seq + 32'd1;
            r_offset  <= r_offset + {16'd0, w_cur_bytes};
            if (w_last_pkt) begin
              r_frame_done <= 1'b1;
              if (enable) begin
                r_pic_seq <= r_pic_seq + 32'd1;
                r_pkt_seq <= '0;
                r_offset  <= '0;
                r_lane    <= '0;
                r_held    <= 1'b0;
                r_state   <= S_FRAME_GAP;
              end else begin
                r_state   <= S_IDLE;
              end
            end else begin
              r_req   <= 1'b1;
              r_state <= S_REQ_UDP;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_img_packetizer.sv
// Scoreboard bench for udp_img_packetizer: expected packet bytes are built per image from the
// header/slicing rules and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_udp_img_packetizer;

  localparam int unsigned W    = 5;
  localparam int unsigned H    = 3;
  localparam int unsigned BPP  = 2;
  localparam int unsigned PAY  = 7;
  localparam int unsigned FGAP = 20;
  localparam int unsigned PGAP = 10;
  localparam logic [31:0] MAGIC = 32'hAA0055FF;
  localparam int unsigned NPIX  = W * H;
  localparam int unsigned IMG_BYTES = NPIX * BPP;
`ifdef UDP_PKT_CHKSUM_EN
  localparam int unsigned HDR_LEN = 34;
`else
  localparam int unsigned HDR_LEN = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, read_req_ack, pix_valid, udp_tx_ready, app_tx_ack;
  logic [31:0] pix_data;
  logic        read_req, pix_ready, app_tx_data_request, app_tx_data_valid, busy, frame_done;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;
  logic [31:0] pic_seq;

  udp_img_packetizer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BYTES_PER_PIX(BPP), .PAYLOAD_BYTES(PAY),
    .HEADER_MAGIC(MAGIC), .FRAME_GAP_CYC(FGAP), .PKT_GAP_CYC(PGAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .read_req(read_req), .read_req_ack(read_req_ack),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .udp_tx_ready(udp_tx_ready), .app_tx_ack(app_tx_ack),
    .app_tx_data_request(app_tx_data_request), .app_tx_data_valid(app_tx_data_valid),
    .app_tx_data(app_tx_data), .udp_data_length(udp_data_length),
    .busy(busy), .frame_done(frame_done), .pic_seq(pic_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    bit          first;
    int unsigned len;
    int unsigned pic;
    int unsigned pkt;
    int unsigned off;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] words[NPIX];
  int unsigned checks = 0, failures = 0;
  int unsigned img_gen = 0, pv_mode = 0;
  int unsigned mon_pkt = 0, mon_off = 0, mon_cnt = 0, fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input bit first, input int unsigned len,
                          input int unsigned pic, input int unsigned pkt, input int unsigned off);
    exp_t e;
    e.data = d; e.first = first; e.len = len; e.pic = pic; e.pkt = pkt; e.off = off;
    exp_q.push_back(e);
  endtask

  // New random image: the byte stream is the used lanes of each pixel word, cut into PAY-byte packets.
  task automatic push_image(input int unsigned seq);
    logic [7:0]  img[IMG_BYTES];
    logic [31:0] hw[8];
    logic [31:0] w;
    logic [15:0] sum;
    int unsigned pos, p, cur;
    for (int unsigned k = 0; k < NPIX; k++) words[k] = $urandom;
    for (int unsigned i = 0; i < IMG_BYTES; i++) begin
      w = words[i / BPP];
      img[i] = w[8 * (4 - BPP + i % BPP) +: 8];
    end
    pos = 0; p = 0;
    while (pos < IMG_BYTES) begin
      cur = (IMG_BYTES - pos < PAY) ? IMG_BYTES - pos : PAY;
      hw = '{MAGIC, W, H, IMG_BYTES, pos, seq, p, cur};
      for (int unsigned b = 0; b < 32; b++) begin
        w = hw[b / 4];
        push_exp(w[8 * (b % 4) +: 8], b == 0, HDR_LEN + cur, seq, p, b);
      end
      sum = '0;
      for (int unsigned j = 0; j < cur; j++) begin
        push_exp(img[pos + j], 1'b0, 0, seq, p, 32 + j);
        sum = sum + {8'd0, img[pos + j]};
      end
`ifdef UDP_PKT_CHKSUM_EN
      push_exp(sum[7:0], 1'b0, 0, seq, p, 32 + cur);
      push_exp(sum[15:8], 1'b0, 0, seq, p, 33 + cur);
`endif
      pos += cur;
      p++;
    end
    img_gen++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_read_req"}, {31'd0, read_req}, 32'd0);
    check({tag, "_pix_ready"}, {31'd0, pix_ready}, 32'd0);
    check({tag, "_request"}, {31'd0, app_tx_data_request}, 32'd0);
    check({tag, "_valid"}, {31'd0, app_tx_data_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, app_tx_data}, 32'd0);
    check({tag, "_len"}, {16'd0, udp_data_length}, 32 + PAY);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_pic_seq"}, pic_seq, 32'd0);
  endtask

  task automatic wait_frame(input int unsigned target);
    int unsigned n = 0;
    while (fd_cnt < target && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    check("frame_done_seen", fd_cnt, target);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    check("frame_done_single", fd_cnt, target);
  endtask

  task automatic summary;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; read_req_ack = 1'b0; pix_valid = 1'b0;
    pix_data = '0; udp_tx_ready = 1'b0; app_tx_ack = 1'b0;
    fork
      // main sequence
      begin
        int unsigned n;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        pv_mode = 0; push_image(1);
        wait_frame(1);
        pv_mode = 1; push_image(2);
        wait_frame(2);
        pv_mode = 2; push_image(3);
        n = 0;
        while (!(mon_pkt == 1 && mon_off == 10) && n < 20000) begin
          @(negedge clk); #1;
          n++;
        end
        check("reached_hdr_byte10", mon_off, 10);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pv_mode = 2; push_image(1);
        @(negedge clk); #1;
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_pic_seq", pic_seq, 32'd1);
        enable = 1'b0;
        wait_frame(3);
        repeat (FGAP + 20) @(negedge clk);
        #1;
        check("final_idle_busy", {31'd0, busy}, 32'd0);
        check("final_pic_seq", pic_seq, 32'd1);
        check("final_queue_empty", exp_q.size(), 0);
        summary();
        $finish;
      end
      // output monitor / scoreboard
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (app_tx_data_valid) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got %02h expected none at %0t", app_tx_data, $time);
              end else begin
                e = exp_q.pop_front();
                check("tx_byte", {24'd0, app_tx_data}, {24'd0, e.data});
                if (e.first) begin
                  check("udp_len", {16'd0, udp_data_length}, e.len);
                  check("pic_seq_out", pic_seq, e.pic);
                end
                mon_pkt = e.pkt;
                mon_off = e.off;
                mon_cnt++;
              end
            end
          end
        end
      end
      // pixel source
      begin
        int unsigned idx = 0, gen_seen = 0, ph = 0;
        bit pend = 1'b0, v;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            pend = 1'b0;
            pix_valid = 1'b0;
          end else begin
            if (gen_seen != img_gen) begin
              gen_seen = img_gen;
              idx = 0;
              pend = 1'b0;
            end else if (pend) begin
              idx++;
            end
            ph++;
            case (pv_mode)
              0:       v = 1'b1;
              1:       v = (ph % 3 == 0);
              default: v = ($urandom_range(0, 1) == 1);
            endcase
            pix_valid = v && (idx < NPIX);
            pix_data  = pix_valid ? words[idx] : $urandom;
            pend = pix_valid && pix_ready;
          end
        end
      end
      // SDRAM read-request responder (third request is held off for 50 cycles)
      begin
        int unsigned req_cnt = 0, d;
        forever begin
          @(negedge clk);
          if (rst_n && read_req) begin
            read_req_ack = 1'b0;
            req_cnt++;
            if (req_cnt == 3) begin
              for (int unsigned i = 0; i < 50; i++) begin
                @(negedge clk);
                check("hold_read_req", {31'd0, read_req}, 32'd1);
                check("hold_no_payload", {31'd0, app_tx_data_valid}, 32'd0);
              end
            end else begin
              d = $urandom_range(0, 3);
              repeat (d) @(negedge clk);
            end
            read_req_ack = 1'b1;
            @(negedge clk);
            if (req_cnt == 3) check("ack_drops_read_req", {31'd0, read_req}, 32'd0);
            read_req_ack = 1'b0;
          end else begin
            read_req_ack = ($urandom_range(0, 7) == 0);
          end
        end
      end
      // UDP stack side
      begin
        forever begin
          @(negedge clk);
          udp_tx_ready = ($urandom_range(0, 3) != 0);
          app_tx_ack   = app_tx_data_request && ($urandom_range(0, 2) == 0);
        end
      end
      // watchdog
      begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        summary();
        $finish;
      end
    join
  end

endmodule
